data_mem_seq: RTL and testbench
===============================

# data_mem_seq

Parametrised, byte-addressable, big-endian data memory with a request/done handshake and byte-serial internal access. It replaces the combinational 256x8 data RAM in the datapath's memory stage. It supports byte, halfword and word transfers, zero- or sign-extended loads, and misalignment/illegal-size error reporting. One byte is accessed per clock, so a transfer takes one cycle per byte plus a completion cycle.

## Interface
Parameters:
- ADDR_W, 8: address width; depth is 2^ADDR_W bytes.
- MISALIGN_CHECK, 1: 1 flags misaligned halfword/word requests as errors; 0 allows them, with byte addresses wrapping modulo 2^ADDR_W.

Ports (clock and reset first):
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 1: request strobe; sampled only in IDLE.
- rw, input, 1: 0 = read, 1 = write.
- size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- sgn, input, 1: reads only; 1 = sign-extend, 0 = zero-extend.
- addr, input, ADDR_W: start byte address.
- din, input, 32: write data; the low 8·N bits are used.
- dout, output, 32: read result, extended to 32 bits.
- busy, output, 1: high whenever state ≠ IDLE.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: valid with done; 1 = request rejected.

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - On a rising edge with req=1, latch rw, size, sgn, addr and din, and clear the byte counter k.
  - N = 1, 2 or 4 for size 00, 01 or 10.
- Error check, evaluated at acceptance:
  - size=11 is an error.
  - With MISALIGN_CHECK=1, a halfword with addr[0]=1 or a word with addr[1:0]≠00 is an error.
  - On error, go straight to DONE with err=1, perform no memory access and leave dout unchanged.
  - Otherwise go to XFER.
- XFER: each cycle moves byte k at address (addr+k) mod 2^ADDR_W. Big-endian: byte 0 is the most significant byte of the N-byte value.
  - Write: mem[addr+k] ← din[8(N−k)−1 -: 8], committed on that cycle's rising edge.
  - Read: mem[addr+k] is shifted into an assembly register on that edge.
  - k increments each cycle; after byte N−1 the state becomes DONE.
- DONE:
  - done=1 for exactly one cycle.
  - For a read, dout is loaded on the XFER→DONE edge, so it is valid throughout DONE. It is the assembled value, zero-extended, or sign-extended from bit 8N−1 when sgn=1.
  - dout holds until the next successful read completes. Writes and errors do not change it.
  - DONE always returns to IDLE on the next edge.
- req while busy=1 is ignored: it is not queued and not latched. The requester must keep req asserted or re-assert it once busy=0.
- Input changes after acceptance have no effect.
- Memory array contents are not reset and are undefined until written.

## Timing
- Acceptance at edge E0. XFER occupies the cycles after edges E0..E(N−1), DONE the cycle after EN, and IDLE returns at E(N+1).
- Latency from the acceptance edge to done:
  - byte: 2 cycles
  - halfword: 3 cycles
  - word: 5 cycles
  - error: 1 cycle
- busy is high for N+1 cycles on success and 1 cycle on error. busy=0 in the same cycle as the completion edge back to IDLE, so back-to-back requests are possible with one IDLE cycle between them.
- Reset values: state=IDLE, busy=0, done=0, err=0, dout=32'h0, k=0.
- Reset asserted mid-XFER aborts immediately. Write bytes already committed remain in memory; the rest are never written. No done is produced for the aborted transfer.
- Reset deasserted coincident with req: req is not accepted on that edge.

## Test plan
- Word write 0xDEADBEEF at 0x10, then word read at 0x10: dout=0xDEADBEEF, done exactly 5 cycles after acceptance, err=0. Byte reads return mem[0x10]=0xDE and mem[0x13]=0xEF.
- After the first test: byte read 0x11 with sgn=0 gives 0x000000AD; byte read 0x10 with sgn=1 gives 0xFFFFFFDE; halfword read 0x12 with sgn=1 gives 0xFFFFBEEF; halfword read 0x12 with sgn=0 gives 0x0000BEEF.
- Halfword write din=0xAAAA1234 at 0x22: mem[0x22]=0x12, mem[0x23]=0x34, and mem[0x21] and mem[0x24] are unchanged. done arrives 3 cycles after acceptance.
- MISALIGN_CHECK=1:
  - Word write at 0x13: done and err=1 one cycle after acceptance, mem[0x13..0x16] unchanged, dout unchanged.
  - size=11 at 0x00: err=1.
- MISALIGN_CHECK=0, ADDR_W=8: word write 0x01020304 at 0xFE gives mem[0xFE]=01, mem[0xFF]=02, mem[0x00]=03, mem[0x01]=04. A word read at 0xFE returns 0x01020304.
- Reset tests:
  - Memory 0x40..0x43 pre-filled with 0x00. Word write 0x11223344 at 0x40, with reset asserted after 2 bytes have committed: mem[0x40]=0x11, mem[0x41]=0x22, mem[0x42..0x43]=0x00, and outputs return to reset values.
  - A req pulse during busy is ignored.

Source files
------------

// File: rtl/data_mem_seq.sv
// Byte-serial, big-endian data memory with a req/done handshake.
// One byte moves per clock; misaligned or illegal-size requests complete at once with err.
module data_mem_seq #(
    parameter int ADDR_W         = 8,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    // Index of the final byte of a transfer (N-1).
    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz, input logic s);
        case (sz)
            2'b00:   return s ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
            2'b01:   return s ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    logic [7:0]        mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic              err_q, err_d;
    logic [31:0]       dout_q, dout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [23:0]       asm_q, asm_d;

    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        wr_sel;
    logic [7:0]        rd_byte;
    logic [7:0]        wr_byte;
    logic              mem_we;
    logic              bad_req;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        rw_d     = rw_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        err_d    = err_q;
        dout_d   = dout_q;
        addr_d   = addr_q;
        din_d    = din_q;
        asm_d    = asm_q;
        mem_we   = 1'b0;
        mem_addr = addr_q + ADDR_W'(k_q);
        rd_byte  = mem[mem_addr];
        // Big-endian: byte k of the transfer is taken from the top of the N-byte field.
        wr_sel   = last_idx(size_q) - k_q;
        wr_byte  = din_q[{wr_sel, 3'b000} +: 8];
        bad_req  = (size == 2'b11) ||
                   (MISALIGN_CHECK && (((size == 2'b01) && addr[0]) ||
                                       ((size == 2'b10) && (addr[1:0] != 2'b00))));

        case (state_q)
            IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    size_d  = size;
                    sgn_d   = sgn;
                    addr_d  = addr;
                    din_d   = din;
                    k_d     = 2'd0;
                    asm_d   = 24'h0;
                    err_d   = bad_req;
                    state_d = bad_req ? DONE : XFER;
                end
            end
            XFER: begin
                mem_we = rw_q;
                asm_d  = {asm_q[15:0], rd_byte};
                k_d    = k_q + 2'd1;
                if (k_q == last_idx(size_q)) begin
                    state_d = DONE;
                    if (!rw_q) begin
                        dout_d = extend({asm_q, rd_byte}, size_q, sgn_q);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Request payload and assembly register carry no reset; they are loaded before use.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        din_q  <= din_d;
        asm_q  <= asm_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_addr] <= wr_byte;
        end
    end

    assign dout = dout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign err  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_data_mem_seq.sv
// Directed bench for data_mem_seq: one instance with misalignment checking, one without.
module tb_data_mem_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req1 = 1'b0, req0 = 1'b0;
    logic        rw = 1'b0, sgn = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [31:0] din = 32'h0;
    logic [31:0] dout1, dout0;
    logic        busy1, done1, err1, busy0, done0, err0;
    logic        sel = 1'b1;

    int passed = 0;
    int total  = 0;

    logic [31:0] rd;
    logic        e;
    int          lat;

    always #5 clk = ~clk;

    data_mem_seq #(.ADDR_W(8), .MISALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req(req1), .rw(rw), .size(size), .sgn(sgn),
        .addr(addr), .din(din), .dout(dout1), .busy(busy1), .done(done1), .err(err1)
    );

    data_mem_seq #(.ADDR_W(8), .MISALIGN_CHECK(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .rw(rw), .size(size), .sgn(sgn),
        .addr(addr), .din(din), .dout(dout0), .busy(busy0), .done(done0), .err(err0)
    );

    wire        done_s = sel ? done1 : done0;
    wire        err_s  = sel ? err1  : err0;
    wire [31:0] dout_s = sel ? dout1 : dout0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // Issue one request, return result, error flag and cycles from acceptance to done.
    task automatic do_op(input logic s, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] r, output logic er, output int l);
        @(negedge clk);
        sel = s; rw = w; size = sz; sgn = sg; addr = a; din = d;
        if (s) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0; req0 = 1'b0;
        l = 1;
        while (!done_s && l < 12) begin
            @(posedge clk); #1;
            l++;
        end
        r  = dout_s;
        er = err_s;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", {31'h0, busy1}, 32'h0);
        chk("reset_done", {31'h0, done1}, 32'h0);
        chk("reset_err",  {31'h0, err1},  32'h0);
        chk("reset_dout", dout1, 32'h0);

        do_op(1, 1, 2'b10, 0, 8'h10, 32'hDEADBEEF, rd, e, lat);
        chk("wr_word_lat", lat, 5);
        chk("wr_word_err", {31'h0, e}, 32'h0);
        chk("wr_word_dout_hold", rd, 32'h0);
        do_op(1, 0, 2'b10, 0, 8'h10, 32'h0, rd, e, lat);
        chk("rd_word", rd, 32'hDEADBEEF);
        chk("rd_word_lat", lat, 5);
        chk("rd_word_err", {31'h0, e}, 32'h0);
        chk("idle_after_done", {30'h0, busy1, done1}, 32'h0);

        do_op(1, 0, 2'b00, 0, 8'h10, 32'h0, rd, e, lat);
        chk("rd_byte_10", rd, 32'h000000DE);
        chk("rd_byte_lat", lat, 2);
        do_op(1, 0, 2'b00, 0, 8'h13, 32'h0, rd, e, lat);
        chk("rd_byte_13", rd, 32'h000000EF);
        do_op(1, 0, 2'b00, 0, 8'h11, 32'h0, rd, e, lat);
        chk("rd_byte_11_zx", rd, 32'h000000AD);
        do_op(1, 0, 2'b00, 1, 8'h10, 32'h0, rd, e, lat);
        chk("rd_byte_10_sx", rd, 32'hFFFFFFDE);
        do_op(1, 0, 2'b01, 1, 8'h12, 32'h0, rd, e, lat);
        chk("rd_half_12_sx", rd, 32'hFFFFBEEF);
        chk("rd_half_lat", lat, 3);
        do_op(1, 0, 2'b01, 0, 8'h12, 32'h0, rd, e, lat);
        chk("rd_half_12_zx", rd, 32'h0000BEEF);

        do_op(1, 1, 2'b10, 0, 8'h20, 32'h55667788, rd, e, lat);
        do_op(1, 1, 2'b10, 0, 8'h24, 32'h99AABBCC, rd, e, lat);
        do_op(1, 1, 2'b01, 0, 8'h22, 32'hAAAA1234, rd, e, lat);
        chk("wr_half_lat", lat, 3);
        do_op(1, 0, 2'b10, 0, 8'h20, 32'h0, rd, e, lat);
        chk("wr_half_bytes", rd, 32'h55661234);
        do_op(1, 0, 2'b00, 0, 8'h24, 32'h0, rd, e, lat);
        chk("wr_half_byte24", rd, 32'h00000099);

        do_op(1, 1, 2'b10, 0, 8'h14, 32'hCAFEF00D, rd, e, lat);
        chk("write_keeps_dout", rd, 32'h00000099);
        do_op(1, 1, 2'b10, 0, 8'h13, 32'h12345678, rd, e, lat);
        chk("misalign_err", {31'h0, e}, 32'h1);
        chk("misalign_lat", lat, 1);
        chk("misalign_dout", rd, 32'h00000099);
        do_op(1, 0, 2'b10, 0, 8'h10, 32'h0, rd, e, lat);
        chk("misalign_no_wr_10", rd, 32'hDEADBEEF);
        do_op(1, 0, 2'b10, 0, 8'h14, 32'h0, rd, e, lat);
        chk("misalign_no_wr_14", rd, 32'hCAFEF00D);
        do_op(1, 0, 2'b11, 0, 8'h00, 32'h0, rd, e, lat);
        chk("size11_err", {31'h0, e}, 32'h1);
        chk("size11_dout", rd, 32'hCAFEF00D);
        do_op(1, 0, 2'b01, 0, 8'h11, 32'h0, rd, e, lat);
        chk("half_misalign_err", {31'h0, e}, 32'h1);

        do_op(0, 1, 2'b10, 0, 8'hFE, 32'h01020304, rd, e, lat);
        chk("wrap_wr_err", {31'h0, e}, 32'h0);
        chk("wrap_wr_lat", lat, 5);
        do_op(0, 0, 2'b10, 0, 8'hFE, 32'h0, rd, e, lat);
        chk("wrap_rd_word", rd, 32'h01020304);
        do_op(0, 0, 2'b00, 0, 8'hFF, 32'h0, rd, e, lat);
        chk("wrap_byte_ff", rd, 32'h00000002);
        do_op(0, 0, 2'b00, 0, 8'h00, 32'h0, rd, e, lat);
        chk("wrap_byte_00", rd, 32'h00000003);
        do_op(0, 0, 2'b00, 0, 8'h01, 32'h0, rd, e, lat);
        chk("wrap_byte_01", rd, 32'h00000004);

        // A second request raised while busy must be dropped, not queued.
        @(negedge clk);
        sel = 1'b1; rw = 1'b0; size = 2'b10; sgn = 1'b0; addr = 8'h10; din = 32'h0; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        rw = 1'b1; size = 2'b00; addr = 8'h10; din = 32'h0; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_req_done", {31'h0, done1}, 32'h1);
        chk("busy_req_dout", dout1, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("busy_req_idle", {30'h0, busy1, done1}, 32'h0);
        @(posedge clk); #1;
        chk("busy_req_not_queued", {31'h0, busy1}, 32'h0);
        do_op(1, 0, 2'b00, 0, 8'h10, 32'h0, rd, e, lat);
        chk("busy_req_no_write", rd, 32'h000000DE);

        // Abort a word write after two bytes have committed.
        do_op(1, 1, 2'b10, 0, 8'h40, 32'h00000000, rd, e, lat);
        @(negedge clk);
        rw = 1'b1; size = 2'b10; addr = 8'h40; din = 32'h11223344; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy1}, 32'h0);
        chk("abort_done", {31'h0, done1}, 32'h0);
        chk("abort_err",  {31'h0, err1},  32'h0);
        chk("abort_dout", dout1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_op(1, 0, 2'b10, 0, 8'h40, 32'h0, rd, e, lat);
        chk("abort_partial", rd, 32'h11220000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
